// File: rtl/scope_pkg.sv
// Shared definitions for the acquisition sequencer: state encoding,
// trigger configuration values and the MCU command codes it serves.
package scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFILL  = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POSTFILL = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam logic TRIG_RISING  = 1'b0;
    localparam logic TRIG_FALLING = 1'b1;
    localparam logic TRIG_AUTO    = 1'b0;
    localparam logic TRIG_NORMAL  = 1'b1;

    // 0x01 carries the run/clear bit; 0x05 reads back the ready flag.
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_READY   = 8'h05;
    localparam logic [7:0] CMD_CODE_15 = 8'h15;
    localparam logic [7:0] CMD_CODE_16 = 8'h16;
    localparam logic [7:0] CMD_CODE_17 = 8'h17;
    localparam logic [7:0] CMD_CODE_1A = 8'h1A;

endpackage

// File: rtl/trig_detect.sv
// Previous-sample holder and edge/level comparator on the selected channel.
// The match is combinational on the sample currently being strobed in.
module trig_detect
    import scope_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sample_en,
    input  logic [DATA_W-1:0] i_ch1_data,
    input  logic [DATA_W-1:0] i_ch2_data,
    input  logic              i_trig_chan,
    input  logic              i_trig_edge,
    input  logic [DATA_W-1:0] i_trig_level,
    output logic              o_match
);

    logic [DATA_W-1:0] prev1_q, prev1_d;
    logic [DATA_W-1:0] prev2_q, prev2_d;
    logic [DATA_W-1:0] cur_s, prev_s;
    logic              hit;

    // Both channels are held so the channel select may change between samples.
    assign prev1_d = i_sample_en ? i_ch1_data : prev1_q;
    assign prev2_d = i_sample_en ? i_ch2_data : prev2_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev1_q <= '0;
            prev2_q <= '0;
        end else begin
            prev1_q <= prev1_d;
            prev2_q <= prev2_d;
        end
    end

    always_comb begin
        cur_s  = i_trig_chan ? i_ch2_data : i_ch1_data;
        prev_s = i_trig_chan ? prev2_q : prev1_q;
        hit    = 1'b0;
        if (i_trig_edge == TRIG_RISING) begin
            hit = (prev_s <= i_trig_level) && (cur_s > i_trig_level);
        end else begin
            hit = (prev_s >= i_trig_level) && (cur_s < i_trig_level);
        end
        o_match = i_sample_en && hit;
    end

endmodule

// File: rtl/acq_trigger_ctrl.sv
// Capture sequencer: circular pre-trigger fill, trigger search, post-trigger
// fill, then freeze and hand a linear read address sequence to the MCU.
module acq_trigger_ctrl
    import scope_pkg::*;
#(
    parameter int                ADDR_W       = 13,
    parameter int                DATA_W       = 8,
    parameter int                TMO_W        = 24,
    parameter logic [TMO_W-1:0]  AUTO_TIMEOUT = 24'd1_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sample_en,
    input  logic [DATA_W-1:0] i_ch1_data,
    input  logic [DATA_W-1:0] i_ch2_data,
    input  logic              i_clear,
    input  logic              i_go,
    input  logic              i_trig_chan,
    input  logic              i_trig_edge,
    input  logic [DATA_W-1:0] i_trig_level,
    input  logic              i_trig_mode,
    input  logic              i_rd_start,
    input  logic              i_rd_next,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data1,
    output logic [DATA_W-1:0] o_wr_data2,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [ADDR_W-1:0] o_trig_addr,
    output logic              o_busy,
    output logic              o_ready,
    output logic              o_forced
);

    localparam int unsigned       HALF_N    = 2 ** (ADDR_W - 1);
    localparam logic [ADDR_W-1:0] HALF      = ADDR_W'(HALF_N);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(HALF_N - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(HALF_N - 2);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_d1_q, wr_d1_d, wr_d2_q, wr_d2_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              forced_q, forced_d;
    logic              write;
    logic              match;

    trig_detect #(.DATA_W(DATA_W)) u_trig_detect (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_sample_en  (i_sample_en),
        .i_ch1_data   (i_ch1_data),
        .i_ch2_data   (i_ch2_data),
        .i_trig_chan  (i_trig_chan),
        .i_trig_edge  (i_trig_edge),
        .i_trig_level (i_trig_level),
        .o_match      (match)
    );

    assign tmo_inc = tmo_q + TMO_W'(1);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_d1_d     = wr_d1_q;
        wr_d2_d     = wr_d2_q;
        trig_addr_d = trig_addr_q;
        rd_addr_d   = rd_addr_q;
        forced_d    = forced_q;
        write       = 1'b0;

        if (i_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_go) begin
                        state_d  = ST_PREFILL;
                        wr_ptr_d = '0;
                        cnt_d    = '0;
                        tmo_d    = '0;
                        forced_d = 1'b0;
                    end
                end
                ST_PREFILL: begin
                    if (i_sample_en) begin
                        write = 1'b1;
                        if (cnt_q == PRE_LAST) begin
                            state_d = ST_ARMED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + ADDR_W'(1);
                        end
                    end
                end
                ST_ARMED: begin
                    if (i_sample_en) begin
                        write = 1'b1;
                        if (match) begin
                            trig_addr_d = wr_ptr_q;
                            state_d     = ST_POSTFILL;
                            cnt_d       = '0;
                        end else if (i_trig_mode == TRIG_AUTO) begin
                            tmo_d = tmo_inc;
                            if (tmo_inc == AUTO_TIMEOUT) begin
                                trig_addr_d = wr_ptr_q;
                                forced_d    = 1'b1;
                                state_d     = ST_POSTFILL;
                                cnt_d       = '0;
                            end
                        end
                    end
                end
                ST_POSTFILL: begin
                    if (i_sample_en) begin
                        write = 1'b1;
                        if (cnt_q == POST_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + ADDR_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_ptr_q;
            wr_d1_d   = i_ch1_data;
            wr_d2_d   = i_ch2_data;
            wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
        end

        // Readout starts at the oldest pre-trigger sample, half a buffer back.
        if (i_rd_start) begin
            rd_addr_d = trig_addr_q - HALF;
        end else if (i_rd_next) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_d1_q     <= '0;
            wr_d2_q     <= '0;
            trig_addr_q <= '0;
            rd_addr_q   <= '0;
            forced_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_d1_q     <= wr_d1_d;
            wr_d2_q     <= wr_d2_d;
            trig_addr_q <= trig_addr_d;
            rd_addr_q   <= rd_addr_d;
            forced_q    <= forced_d;
        end
    end

    assign o_wr_en     = wr_en_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data1  = wr_d1_q;
    assign o_wr_data2  = wr_d2_q;
    assign o_rd_addr   = rd_addr_q;
    assign o_trig_addr = trig_addr_q;
    assign o_forced    = forced_q;
    assign o_ready     = (state_q == ST_DONE);
    assign o_busy      = (state_q == ST_PREFILL) || (state_q == ST_ARMED) ||
                         (state_q == ST_POSTFILL);

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// Bench for acq_trigger_ctrl: directed scenarios plus random traffic, checked
// every cycle against a sample-count model of the capture.
module tb_acq_trigger_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int HALF  = 8;
    localparam int TO    = 5;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_sample_en = 1'b0;
    logic [DW-1:0] i_ch1_data = '0, i_ch2_data = '0;
    logic          i_clear = 1'b0, i_go = 1'b0;
    logic          i_trig_chan = 1'b0, i_trig_edge = 1'b0, i_trig_mode = 1'b1;
    logic [DW-1:0] i_trig_level = 8'h80;
    logic          i_rd_start = 1'b0, i_rd_next = 1'b0;
    logic          o_wr_en, o_busy, o_ready, o_forced;
    logic [AW-1:0] o_wr_addr, o_rd_addr, o_trig_addr;
    logic [DW-1:0] o_wr_data1, o_wr_data2;

    acq_trigger_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TMO_W(24), .AUTO_TIMEOUT(24'd5)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sample_en(i_sample_en),
        .i_ch1_data(i_ch1_data), .i_ch2_data(i_ch2_data),
        .i_clear(i_clear), .i_go(i_go), .i_trig_chan(i_trig_chan),
        .i_trig_edge(i_trig_edge), .i_trig_level(i_trig_level),
        .i_trig_mode(i_trig_mode), .i_rd_start(i_rd_start), .i_rd_next(i_rd_next),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data1(o_wr_data1),
        .o_wr_data2(o_wr_data2), .o_rd_addr(o_rd_addr), .o_trig_addr(o_trig_addr),
        .o_busy(o_busy), .o_ready(o_ready), .o_forced(o_forced)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a capture is a run of n accepted samples counted from i_go.
    // Sample k lands at k mod DEPTH; triggers are searched from sample HALF
    // on, and the capture ends HALF samples after the trigger sample.
    bit            m_active = 0, m_done = 0, m_forced = 0;
    int            n = 0, tidx = -1, tmo = 0;
    logic [DW-1:0] p1 = '0, p2 = '0;
    logic          e_wr_en = 0;
    logic [AW-1:0] e_wr_addr = '0, e_trig = '0, e_rd = '0;
    logic [DW-1:0] e_d1 = '0, e_d2 = '0;

    function automatic bit crosses(input logic [DW-1:0] p, s, lvl, input logic fall);
        if (fall) return (p >= lvl) && (s < lvl);
        return (p <= lvl) && (s > lvl);
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        logic [DW-1:0] s, p;
        if (!i_rst_n) begin
            m_active = 0; m_done = 0; m_forced = 0; n = 0; tidx = -1; tmo = 0;
            p1 = '0; p2 = '0; e_wr_en = 0; e_wr_addr = '0; e_trig = '0; e_rd = '0;
            e_d1 = '0; e_d2 = '0;
        end else begin
            if (i_rd_start) e_rd = AW'((int'(e_trig) - HALF + DEPTH) % DEPTH);
            else if (i_rd_next) e_rd = AW'((int'(e_rd) + 1) % DEPTH);
            e_wr_en = 0;
            s = i_trig_chan ? i_ch2_data : i_ch1_data;
            p = i_trig_chan ? p2 : p1;
            if (i_clear) begin
                m_active = 0; m_done = 0;
            end else if (i_go && !m_active) begin
                m_active = 1; m_done = 0; m_forced = 0; n = 0; tidx = -1; tmo = 0;
            end else if (m_active && i_sample_en) begin
                e_wr_en = 1; e_wr_addr = AW'(n % DEPTH); e_d1 = i_ch1_data; e_d2 = i_ch2_data;
                if (tidx < 0 && n >= HALF) begin
                    if (crosses(p, s, i_trig_level, i_trig_edge)) tidx = n;
                    else if (i_trig_mode == 1'b0) begin
                        tmo++;
                        if (tmo == TO) begin tidx = n; m_forced = 1; end
                    end
                    if (tidx == n) e_trig = AW'(n % DEPTH);
                end
                n++;
                if (tidx >= 0 && n == tidx + HALF) begin m_active = 0; m_done = 1; end
            end
            if (i_sample_en) begin p1 = i_ch1_data; p2 = i_ch2_data; end
        end
    end

    always @(negedge i_clk) begin
        cmp("wr_en", o_wr_en, e_wr_en);
        cmp("wr_addr", o_wr_addr, e_wr_addr);
        cmp("wr_data1", o_wr_data1, e_d1);
        cmp("wr_data2", o_wr_data2, e_d2);
        cmp("trig_addr", o_trig_addr, e_trig);
        cmp("rd_addr", o_rd_addr, e_rd);
        cmp("busy", o_busy, m_active);
        cmp("ready", o_ready, m_done);
        cmp("forced", o_forced, m_forced);
    end

    task automatic tick();
        @(posedge i_clk); #1;
    endtask

    task automatic pulse_go();
        i_go = 1'b1; tick(); i_go = 1'b0;
    endtask

    task automatic samp(input logic [DW-1:0] a, input logic [DW-1:0] b);
        i_sample_en = 1'b1; i_ch1_data = a; i_ch2_data = b; tick();
        i_sample_en = 1'b0; tick();
    endtask

    task automatic cfg(input logic chan, input logic fall, input logic [DW-1:0] lvl, input logic mode);
        i_trig_chan = chan; i_trig_edge = fall; i_trig_level = lvl; i_trig_mode = mode;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        cmp("reset_busy", o_busy, 0);
        cmp("reset_ready", o_ready, 0);
        cmp("reset_wr_en", o_wr_en, 0);
        cmp("reset_trig", o_trig_addr, 0);
        i_rst_n = 1'b1; tick();

        // Rising ramp: trigger on 0x90 (predecessor 0x80 <= level) at address 9.
        cfg(0, 0, 8'h80, 1);
        pulse_go();
        cmp("ramp_busy", o_busy, 1);
        for (int k = 0; k < 17; k++) begin
            samp(8'(k * 16), 8'h00);
            cmp("ramp_wr_addr", o_wr_addr, k % DEPTH);
            if (k == 8) cmp("ramp_no_trig_on_equal", o_busy && o_trig_addr == 4'd0, 1);
            if (k == 9) cmp("ramp_trig_addr", o_trig_addr, 9);
            if (k == 15) cmp("ramp_not_ready_early", o_ready, 0);
        end
        cmp("ramp_ready", o_ready, 1);
        cmp("ramp_busy_done", o_busy, 0);
        i_sample_en = 1'b1; tick(); i_sample_en = 1'b0;
        cmp("ramp_no_write_done", o_wr_en, 0);
        i_rd_start = 1'b1; tick(); i_rd_start = 1'b0;
        cmp("ramp_rd_start", o_rd_addr, 1);

        // Trigger after a wrap at address 2; readout walks 10..15,0..9.
        pulse_go();
        for (int k = 0; k < 18; k++) samp(8'h00, 8'h00);
        samp(8'hFF, 8'h00);
        cmp("wrap_trig_addr", o_trig_addr, 2);
        i_rd_start = 1'b1; i_rd_next = 1'b1; tick(); i_rd_start = 1'b0;
        cmp("wrap_rd_start", o_rd_addr, 10);
        for (int i = 0; i < 15; i++) begin
            tick();
            cmp("wrap_rd_next", o_rd_addr, (11 + i) % DEPTH);
        end
        i_rd_next = 1'b0;
        for (int k = 0; k < 7; k++) samp(8'hFF, 8'h00);
        cmp("wrap_ready", o_ready, 1);

        // Auto mode: forced trigger on the 5th ARMED sample (sample 12).
        cfg(0, 0, 8'h80, 0);
        pulse_go();
        cmp("auto_ready_cleared", o_ready, 0);
        for (int k = 0; k < 12; k++) samp(8'h40, 8'h40);
        cmp("auto_not_forced_yet", o_forced, 0);
        samp(8'h40, 8'h40);
        cmp("auto_forced", o_forced, 1);
        cmp("auto_trig_addr", o_trig_addr, 12);
        for (int k = 0; k < 6; k++) samp(8'h40, 8'h40);
        cmp("auto_not_ready", o_ready, 0);
        samp(8'h40, 8'h40);
        cmp("auto_ready", o_ready, 1);

        // Normal mode with the same input never triggers.
        cfg(0, 0, 8'h80, 1);
        pulse_go();
        cmp("normal_forced_cleared", o_forced, 0);
        for (int k = 0; k < 30; k++) samp(8'h40, 8'h40);
        cmp("normal_never_ready", o_ready, 0);
        cmp("normal_still_busy", o_busy, 1);
        i_clear = 1'b1; tick(); i_clear = 1'b0;
        cmp("normal_clear_idle", o_busy, 0);

        // Falling on ch2: ch1 falls and 0x80->0x80 do not match; 0x90->0x70 does.
        cfg(1, 1, 8'h80, 1);
        pulse_go();
        for (int k = 0; k < 8; k++) samp(8'hFF, 8'hFF);
        samp(8'h00, 8'hFF);
        samp(8'h00, 8'h80);
        samp(8'h00, 8'h80);
        samp(8'h00, 8'h80);
        samp(8'h00, 8'h90);
        cmp("fall_no_trig_yet", o_trig_addr, 12);
        samp(8'h00, 8'h70);
        cmp("fall_trig_addr", o_trig_addr, 13);
        for (int k = 0; k < 7; k++) samp(8'h00, 8'h70);
        cmp("fall_ready", o_ready, 1);

        // Clear mid-POSTFILL, then go together with clear stays idle.
        cfg(0, 0, 8'h80, 1);
        pulse_go();
        for (int k = 0; k < 13; k++) samp(8'(k * 16), 8'h00);
        cmp("clr_busy_before", o_busy, 1);
        i_clear = 1'b1; i_sample_en = 1'b1; tick(); i_sample_en = 1'b0;
        cmp("clr_busy", o_busy, 0);
        cmp("clr_ready", o_ready, 0);
        cmp("clr_no_write", o_wr_en, 0);
        samp(8'h55, 8'h55);
        i_go = 1'b1; tick(); i_go = 1'b0;
        cmp("clr_go_stays_idle", o_busy, 0);
        i_clear = 1'b0; tick();
        cmp("clr_trig_kept", o_trig_addr, 9);

        // Reset mid-ARMED clears every output at once; restart writes from 0.
        cfg(0, 0, 8'hFF, 1);
        pulse_go();
        for (int k = 0; k < 10; k++) samp(8'(k), 8'h00);
        cmp("rst_armed_busy", o_busy, 1);
        i_rst_n = 1'b0; #1;
        cmp("rst_all_zero", |{o_wr_en, o_wr_addr, o_wr_data1, o_wr_data2, o_rd_addr,
                              o_trig_addr, o_busy, o_ready, o_forced}, 0);
        tick(); tick();
        i_rst_n = 1'b1; tick();
        pulse_go();
        i_sample_en = 1'b1; i_ch1_data = 8'h5A; tick(); i_sample_en = 1'b0;
        cmp("rst_restart_wr_en", o_wr_en, 1);
        cmp("rst_restart_addr", o_wr_addr, 0);
        cmp("rst_restart_data", o_wr_data1, 8'h5A);
        tick();

        // Random traffic; values near the threshold make edges frequent.
        for (int c = 0; c < 4000; c++) begin
            i_sample_en = ($urandom_range(0, 2) == 0);
            i_ch1_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(8'h70, 8'h90));
            i_ch2_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(8'h70, 8'h90));
            i_go        = ($urandom_range(0, 19) == 0);
            i_clear     = ($urandom_range(0, 149) == 0);
            i_rd_start  = ($urandom_range(0, 29) == 0);
            i_rd_next   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0)
                cfg(1'($urandom), 1'($urandom), 8'($urandom_range(8'h78, 8'h88)), 1'($urandom));
            tick();
        end
        i_sample_en = 1'b0; i_go = 1'b0; i_clear = 1'b0; i_rd_start = 1'b0; i_rd_next = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
